// File: rtl/uart_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_stream_fifo
//  Purpose  : Synchronous byte FIFO between a UART receive stream and a UART
//             transmit stream. A DEPTH-entry RAM feeds one registered output
//             stage, so total capacity is DEPTH+1 bytes.
//  Ports    : clk          - system clock, rising edge
//             rst_n        - synchronous active-low reset
//             i_in_valid   - producer has a byte
//             i_in_data    - byte to store
//             o_in_ready   - FIFO can accept (from registered pointers only)
//             o_out_valid  - o_out_data holds a valid byte
//             o_out_data   - head-of-queue byte, registered
//             i_out_ready  - consumer takes the byte
//             o_level      - occupancy 0..DEPTH+1    (UART_FIFO_STATUS_EN only)
//             o_overflow   - sticky write-while-full (UART_FIFO_STATUS_EN only)
//  Options  : define UART_FIFO_STATUS_EN to add o_level and o_overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_stream_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_in_valid,
    input  logic [DATA_W-1:0]              i_in_data,
    output logic                           o_in_ready,
    output logic                           o_out_valid,
    output logic [DATA_W-1:0]              o_out_data,
`ifdef UART_FIFO_STATUS_EN
    output logic [$clog2(DEPTH+1):0]       o_level,
    output logic                           o_overflow,
`endif
    input  logic                           i_out_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               ram_empty;
    logic               ram_full;
    logic               wr_en;
    logic               load;

    assign ram_empty = (wr_ptr_q == rd_ptr_q);
    assign ram_full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                       (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

    // Ready looks only at RAM fullness; a pop from the output stage in the
    // same cycle frees space only after the following RAM read moves rd_ptr.
    assign wr_en = i_in_valid && !ram_full;
    assign load  = (!out_valid_q || i_out_ready) && !ram_empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end

        // No write-to-output bypass: the stage only ever loads from RAM.
        if (load) begin
            out_data_d  = mem[rd_ptr_q[PTR_W-1:0]];
            out_valid_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + C_PTR_ONE;
        end else if (i_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage is not reset; writes at a reset edge are suppressed so the
    // input presented there has no effect at all.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= i_in_data;
        end
    end

    assign o_in_ready  = !ram_full;
    assign o_out_valid = out_valid_q;
    assign o_out_data  = out_data_q;

`ifdef UART_FIFO_STATUS_EN
    localparam int LVL_W = $clog2(DEPTH + 1) + 1;

    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (i_in_valid && ram_full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    // The pointer difference is exact modulo 2*DEPTH, which covers 0..DEPTH.
    assign o_level    = LVL_W'(wr_ptr_q - rd_ptr_q) + LVL_W'(out_valid_q);
    assign o_overflow = overflow_q;
`endif

endmodule
`default_nettype wire

// File: doc/uart_stream_fifo.md
Name: uart_stream_fifo

Overview:
- Synchronous byte FIFO that sits between the UART interface's receive stream and its transmit stream.
- Accepts bytes from the RX valid/ready producer side and presents them, in order, to the TX valid/ready consumer side.
- Decouples bursty receive traffic from the bit-serial transmit rate. Used directly, it forms a buffered UART loopback/echo path.
- Storage is a DEPTH-entry RAM plus one registered output stage, so total capacity is DEPTH+1 bytes.

Parameters:
DATA_W, 8, byte width of each entry
DEPTH, 16, RAM entries; must be a power of 2 and >= 2
PTR_W, $clog2(DEPTH), RAM address width; derived, not for override

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk
i_in_valid  input  1  producer has a byte (driven by the UART RX valid)
i_in_data  input  DATA_W  byte to store
o_in_ready  output  1  FIFO can accept; transfer occurs when i_in_valid && o_in_ready
o_out_valid  output  1  o_out_data holds a valid byte
o_out_data  output  DATA_W  head-of-queue byte, registered
i_out_ready  input  1  consumer takes the byte (driven by the UART TX ready); transfer occurs when o_out_valid && i_out_ready

Behaviour:
- Reset (rst_n low at a clk edge):
  - wr_ptr, rd_ptr = 0 (each PTR_W+1 bits, MSB is the wrap bit).
  - o_out_valid=0, o_out_data=0, o_in_ready=1 (after the reset edge).
  - RAM contents are not cleared.
- Reset mid-operation discards all stored bytes, including the output stage, at that edge. Inputs presented at that edge are ignored.
- Pointer flags:
  - ram_empty = (wr_ptr == rd_ptr).
  - ram_full = (addresses equal) && (wrap bits differ).
- o_in_ready = !ram_full, from registered pointers only. A same-cycle output pop never raises o_in_ready combinationally.
- Write: on accept, RAM[wr_ptr[PTR_W-1:0]] <= i_in_data and wr_ptr increments. The pointer wraps naturally modulo 2*DEPTH.
- Output stage load condition: (!o_out_valid || i_out_ready) && !ram_empty.
  - On load: o_out_data <= RAM[rd_ptr], o_out_valid <= 1, rd_ptr increments.
  - Else if i_out_ready: o_out_valid <= 0.
  - Else: hold data and valid.
- No write-to-output bypass. A byte accepted into an empty FIFO at edge N is stored in RAM at N, loaded into the output stage at N+1, and o_out_valid is high after N+1. Latency is 2 edges.
- Simultaneous write and output load in one cycle is allowed. The RAM count is then unchanged, and ram_empty and ram_full are both evaluated on pre-edge pointers.
- o_out_data is stable while o_out_valid=1 && i_out_ready=0.
- i_in_valid while o_in_ready=0: the byte is dropped and the FIFO state is unchanged.
- i_out_ready while o_out_valid=0: no effect.
- Byte order is strictly preserved across pointer wrap.

Optional Feature:
- Macro: UART_FIFO_STATUS_EN.
- Defined:
  - Adds port o_level, output, $clog2(DEPTH+1)+1 bits: (wr_ptr - rd_ptr) + o_out_valid, registered-state based, range 0..DEPTH+1.
  - Adds port o_overflow, output, 1 bit: sticky; set at the edge where i_in_valid=1 && o_in_ready=0; cleared only by reset.
  - Reset value of both is 0.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- DEPTH=4, empty, write 0xA5 at edge 1 with i_out_ready=0 -> o_out_valid=1, o_out_data=0xA5 after edge 2; remains held for 10 cycles; o_in_ready stays 1.
- DEPTH=4, i_out_ready=0, drive i_in_valid=1 with 0x01..0x06 back-to-back -> exactly 0x01..0x05 accepted; o_in_ready=0 after the 5th accept; 0x06 dropped; with STATUS_EN, o_level=5 and o_overflow=1.
- From the full state above, set i_out_ready=1 -> outputs 0x01,0x02,0x03,0x04,0x05 on consecutive cycles; o_out_valid=0 afterwards; o_in_ready=1 one edge after the first RAM read.
- DEPTH=4, 40 bytes 0x00..0x27 with i_in_valid and i_out_ready each randomly toggled -> output sequence exactly 0x00..0x27; no loss or duplication across multiple pointer wraps.
- Steady state, 2 bytes stored, i_in_valid=1 and i_out_ready=1 for 20 cycles -> one byte in and one out per cycle; occupancy constant at 2 (o_level=2 with STATUS_EN).
- Load 3 bytes, assert rst_n=0 for one edge with i_in_valid=1 -> after reset o_out_valid=0, o_in_ready=1, o_overflow=0; the next written byte 0x5A is the first byte output.
